ram_addr_ctrl_serpentine: RTL and testbench
===========================================

// Module: ram_addr_ctrl_serpentine
// PURPOSE
// - Parametrised serpentine read-address generator for the line-buffer RAM feeding the DoG/extrema window.
// - Each beat: WIN parallel RAM addresses, one per window row, for one image column; band y walks columns
//   L->R (dir=0) or R->L (dir=1), alternating per band, y = 0..IMG_H-WIN.
// - Adds start/ready handshake, frame_done, window-valid flag and generic WIN/IMG sizes.
// PARAMETERS
// - IMG_W   256  image width in pixels (>= WIN)
// - IMG_H   256  image height in lines (>= WIN)
// - WIN     5    window height = parallel address lanes (>= 1)
// - AW      16   address width; IMG_W*IMG_H <= 2**AW (RAM_BASE_EN: addresses wrap mod 2**AW)
// - XW      8    coordinate width; 2**XW >= max(IMG_W, IMG_H)
// PORTS
// - clk        in   1       rising-edge clock
// - rst        in   1       synchronous, active-high reset
// - start      in   1       frame start request; sampled only in IDLE
// - ready      in   1       downstream accepts beat when valid&ready
// - addr_base  in   AW      frame base address (present only with RAM_BASE_EN)
// - valid      out  1       addr/x/y/dir/win_valid hold a beat
// - addr       out  WIN*AW  lane k in [k*AW +: AW] = (y+k)*IMG_W + col (+base)
// - x_out      out  XW      column col of current beat
// - y_out      out  XW      band index y (top window row)
// - dir_out    out  1       0 = L->R band, 1 = R->L band
// - win_valid  out  1       beat index within band >= WIN-1 (full WINxWIN window available)
// - busy       out  1       high in RUN
// - frame_done out  1       one-cycle pulse after last beat accepted
// BEHAVIOUR
// - Reset (sync, priority over all): state=IDLE; every output 0; internal counters 0.
// - FSM IDLE: start=1 -> RUN; first beat presented next cycle (valid=1, y=0, dir=0, col=0).
// - FSM RUN: beat index n=0..IMG_W-1 per band; col = dir ? IMG_W-1-n : n.
// - Advance only on valid&ready; otherwise all outputs and counters hold (no change while stalled).
// - On handshake with n=IMG_W-1: n->0, y->y+1, dir toggles; row base += IMG_W (adder, no multiplier).
// - On handshake of final beat (y=IMG_H-WIN, n=IMG_W-1): next cycle valid=0, busy=0,
//   frame_done=1 for exactly one cycle, state=IDLE; x_out/y_out/dir_out/addr keep last values.
// - start during RUN ignored; start in frame_done cycle accepted (state already IDLE).
// - Total beats per frame = (IMG_H-WIN+1)*IMG_W; valid never deasserts mid-frame.
// - Lane addresses registered; lane k = lane 0 + k*IMG_W; all sums computed AW bits, truncated.
// - Reset mid-frame: aborts immediately, no frame_done pulse.
// CONFIGURATION
// - RAM_BASE_EN defined: port addr_base present; latched on accepted start; added to every lane,
//   wrap mod 2**AW (ping-pong frame buffers).
// - RAM_BASE_EN undefined: port absent; base = 0.
// TESTING (IMG_W=8, IMG_H=6, WIN=3, AW=16, XW=8 unless stated)
// - rst=1 two cycles -> valid=busy=frame_done=win_valid=0, addr=0, x/y/dir=0.
// - start pulse, ready=1 -> beat0 lanes {0,8,16} col0 dir0 win_valid=0; beat2 win_valid=1;
//   beat8 lanes {15,23,31} col7 y1 dir1; beat31 lanes {24,32,40} col0 y3; frame_done 1 cycle later, 32 beats.
// - ready=0 for 3 cycles at beat5 -> addr {5,13,21}, x_out=5 held 3 cycles, then beat6 {6,14,22}.
// - rst=1 at beat12 -> next cycle all outputs 0, IDLE, no frame_done; new start restarts at {0,8,16}.
// - start held high throughout -> ignored in RUN; new frame begins beat0 one cycle after frame_done cycle.
// - RAM_BASE_EN, addr_base=16'h0100 -> beat0 {0x100,0x108,0x110}; base 16'hFFF8 -> beat0 lane1 = 0x0000.

Source files
------------

// File: rtl/ram_addr_ctrl_serpentine.sv
// ram_addr_ctrl_serpentine
//   Serpentine read-address generator for the line-buffer RAM that feeds the
//   DoG/extrema window. Every beat carries WIN parallel RAM addresses, one per
//   window row, for a single image column. Band y (top window row) walks the
//   columns L->R when y is even and R->L when y is odd, for y = 0..IMG_H-WIN.
//
//   Optional feature macro: RAM_BASE_EN
//     When it is defined, the addr_base port exists. It is latched on an
//     accepted start and added to every lane, wrapping mod 2**AW.
//     When it is undefined, the port is absent and the base is 0.
//
//   Ports
//     clk, rst    rising-edge clock, synchronous active-high reset
//     start       frame start request, sampled only while idle
//     ready       downstream accept; a beat advances on valid & ready
//     addr_base   frame base address (RAM_BASE_EN only)
//     valid       the beat outputs below hold a beat
//     addr        lane k at [k*AW +: AW] = (y+k)*IMG_W + col (+ base)
//     x_out       column of the current beat
//     y_out       band index (top window row)
//     dir_out     0 = L->R band, 1 = R->L band
//     win_valid   beat index within the band >= WIN-1
//     busy        frame in progress
//     frame_done  one-cycle pulse after the last beat is accepted
module ram_addr_ctrl_serpentine #(
   parameter int unsigned IMG_W = 256,
   parameter int unsigned IMG_H = 256,
   parameter int unsigned WIN   = 5,
   parameter int unsigned AW    = 16,
   parameter int unsigned XW    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ready,
`ifdef RAM_BASE_EN
   input  logic [AW-1:0]     addr_base,
`endif
   output logic              valid,
   output logic [WIN*AW-1:0] addr,
   output logic [XW-1:0]     x_out,
   output logic [XW-1:0]     y_out,
   output logic              dir_out,
   output logic              win_valid,
   output logic              busy,
   output logic              frame_done
);

   localparam int unsigned LW = WIN * AW;
   localparam logic [XW-1:0] N_LAST   = XW'(IMG_W - 1);
   localparam logic [XW-1:0] Y_LAST   = XW'(IMG_H - WIN);
   localparam logic [XW-1:0] WV_FIRST = XW'(WIN - 1);
   localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [XW-1:0] n_q, n_d;
   logic [XW-1:0] y_q, y_d;
   logic [XW-1:0] x_q, x_d;
   logic          dir_q, dir_d;
   logic [AW-1:0] row_base_q, row_base_d;
   logic [LW-1:0] addr_q, addr_d;
   logic          valid_q, valid_d;
   logic          wv_q, wv_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          frame_go;
   logic          beat_acc;
   logic          band_end;
   logic          frame_end;
   logic          load_beat;
   logic [AW-1:0] frame_base;
   logic [XW-1:0] col;
   logic [AW-1:0] lane0;
   logic [LW-1:0] lanes;

`ifdef RAM_BASE_EN
   assign frame_base = addr_base;
`else
   assign frame_base = '0;
`endif

   assign frame_go  = (state_q == ST_IDLE) && start;
   assign beat_acc  = (state_q == ST_RUN) && valid_q && ready;
   assign band_end  = (n_q == N_LAST);
   assign frame_end = beat_acc && band_end && (y_q == Y_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)     state_d = ST_RUN;
         ST_RUN:  if (frame_end) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Scan counters and handshake flags; everything holds unless a beat is accepted
   always_comb begin
      n_d        = n_q;
      y_d        = y_q;
      dir_d      = dir_q;
      row_base_d = row_base_q;
      valid_d    = valid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      load_beat  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_go) begin
               n_d        = '0;
               y_d        = '0;
               dir_d      = 1'b0;
               row_base_d = frame_base;
               valid_d    = 1'b1;
               busy_d     = 1'b1;
               load_beat  = 1'b1;
            end
         end
         ST_RUN: begin
            if (frame_end) begin
               // Last beat taken: beat fields keep their final values
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (beat_acc) begin
               load_beat = 1'b1;
               if (band_end) begin
                  n_d        = '0;
                  y_d        = y_q + XW'(1);
                  dir_d      = ~dir_q;
                  row_base_d = row_base_q + ROW_STEP;
               end else begin
                  n_d = n_q + XW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // Beat formation: column from direction, lane k offset by k rows
   always_comb begin
      col   = dir_d ? (N_LAST - n_d) : n_d;
      lane0 = row_base_d + AW'(col);
      lanes = '0;
      for (int unsigned k = 0; k < WIN; k++) begin
         lanes[k*AW +: AW] = lane0 + AW'(k * IMG_W);
      end
      x_d    = x_q;
      addr_d = addr_q;
      wv_d   = wv_q;
      if (load_beat) begin
         x_d    = col;
         addr_d = lanes;
         wv_d   = (n_d >= WV_FIRST);
      end else if (frame_end) begin
         wv_d = 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q        <= '0;
         y_q        <= '0;
         x_q        <= '0;
         dir_q      <= 1'b0;
         row_base_q <= '0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
         wv_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         n_q        <= n_d;
         y_q        <= y_d;
         x_q        <= x_d;
         dir_q      <= dir_d;
         row_base_q <= row_base_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         wv_q       <= wv_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign valid      = valid_q;
   assign addr       = addr_q;
   assign x_out      = x_q;
   assign y_out      = y_q;
   assign dir_out    = dir_q;
   assign win_valid  = wv_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_ram_addr_ctrl_serpentine.sv
// Testbench for ram_addr_ctrl_serpentine (IMG_W=8, IMG_H=6, WIN=3, AW=16, XW=8).
module tb_ram_addr_ctrl_serpentine;

   localparam int IMG_W = 8;
   localparam int IMG_H = 6;
   localparam int WIN   = 3;
   localparam int AW    = 16;
   localparam int XW    = 8;
   localparam int BEATS = (IMG_H - WIN + 1) * IMG_W;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic ready;
`ifdef RAM_BASE_EN
   logic [AW-1:0] addr_base;
`endif
   logic              valid;
   logic [WIN*AW-1:0] addr;
   logic [XW-1:0]     x_out;
   logic [XW-1:0]     y_out;
   logic              dir_out;
   logic              win_valid;
   logic              busy;
   logic              frame_done;

   int checks = 0;
   int errors = 0;
   int cur_base = 0;

   typedef struct {
      logic [WIN*AW-1:0] addr;
      int                col;
      int                y;
      bit                dir;
      bit                wv;
   } beat_t;
   beat_t exp_q[$];

   typedef struct {
      int beat;
      int l0;
      int l1;
      int l2;
      int col;
      int y;
      bit dir;
      bit wv;
   } vec_t;
   vec_t vecs[5];

   logic [WIN*AW-1:0] cap_addr[64];
   int                cap_x[64];
   int                cap_y[64];
   bit                cap_dir[64];
   bit                cap_wv[64];
   int                nb;
   int                idx;
   bit                seen;
   bit                bad;
   beat_t             b;

   ram_addr_ctrl_serpentine #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .AW(AW), .XW(XW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ready     (ready),
`ifdef RAM_BASE_EN
      .addr_base (addr_base),
`endif
      .valid     (valid),
      .addr      (addr),
      .x_out     (x_out),
      .y_out     (y_out),
      .dir_out   (dir_out),
      .win_valid (win_valid),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WIN*AW-1:0] pack3(input int l0, input int l1, input int l2);
      return {AW'(l2), AW'(l1), AW'(l0)};
   endfunction

   // Reference: lane k of band y at column col is (y+k)*IMG_W + col + base, mod 2**AW
   function automatic logic [WIN*AW-1:0] model_addr(input int y, input int col);
      logic [WIN*AW-1:0] r;
      for (int k = 0; k < WIN; k++) r[k*AW +: AW] = AW'(cur_base + (y + k) * IMG_W + col);
      return r;
   endfunction

   task automatic fill_model();
      beat_t m;
      exp_q.delete();
      for (int y = 0; y <= IMG_H - WIN; y++) begin
         for (int n = 0; n < IMG_W; n++) begin
            m.dir  = ((y % 2) == 1);
            m.col  = m.dir ? (IMG_W - 1 - n) : n;
            m.y    = y;
            m.wv   = (n >= WIN - 1);
            m.addr = model_addr(y, m.col);
            exp_q.push_back(m);
         end
      end
   endtask

   task automatic set_base(input logic [AW-1:0] bv);
`ifdef RAM_BASE_EN
      addr_base = bv;
      cur_base  = int'(bv);
`else
      cur_base  = (bv == '1) ? 0 : 0;
`endif
   endtask

   task automatic start_frame();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_to_done(input string name);
      bit got;
      got = 1'b0;
      ready = 1'b1;
      for (int c = 0; c < 300; c++) begin
         if (frame_done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk(name, 64'(got), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{0,  0,  8,  16, 0, 0, 1'b0, 1'b0};
      vecs[1] = '{2,  2,  10, 18, 2, 0, 1'b0, 1'b1};
      vecs[2] = '{8,  15, 23, 31, 7, 1, 1'b1, 1'b0};
      vecs[3] = '{12, 11, 19, 27, 3, 1, 1'b1, 1'b1};
      vecs[4] = '{31, 24, 32, 40, 0, 3, 1'b1, 1'b1};

      rst = 1'b1; start = 1'b0; ready = 1'b0;
      set_base('0);
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(frame_done), 64'd0);
      chk("rst_wv", 64'(win_valid), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);
      chk("rst_x", 64'(x_out), 64'd0);
      chk("rst_y", 64'(y_out), 64'd0);
      chk("rst_dir", 64'(dir_out), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_valid", 64'(valid), 64'd0);
      chk("idle_addr", 64'(addr), 64'd0);

      // Full frame with ready=1; captured beats are checked against the vector table
      ready = 1'b1;
      start_frame();
      nb = 0; seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
         if (valid && nb < 64) begin
            cap_addr[nb] = addr;
            cap_x[nb]    = int'(x_out);
            cap_y[nb]    = int'(y_out);
            cap_dir[nb]  = dir_out;
            cap_wv[nb]   = win_valid;
            nb++;
         end
         @(negedge clk);
      end
      chk("t1_done_seen", 64'(seen), 64'd1);
      chk("t1_beats", 64'(nb), 64'(BEATS));
      chk("t1_done_valid", 64'(valid), 64'd0);
      chk("t1_done_busy", 64'(busy), 64'd0);
      chk("t1_hold_addr", 64'(addr), 64'(pack3(24, 32, 40)));
      chk("t1_hold_x", 64'(x_out), 64'd0);
      chk("t1_hold_y", 64'(y_out), 64'd3);
      chk("t1_hold_dir", 64'(dir_out), 64'd1);
      @(negedge clk);
      chk("t1_done_pulse", 64'(frame_done), 64'd0);
      for (int i = 0; i < 5; i++) begin
         idx = vecs[i].beat;
         chk($sformatf("vec%0d_addr", i), 64'(cap_addr[idx]),
             64'(pack3(vecs[i].l0, vecs[i].l1, vecs[i].l2)));
         chk($sformatf("vec%0d_x", i), 64'(cap_x[idx]), 64'(vecs[i].col));
         chk($sformatf("vec%0d_y", i), 64'(cap_y[idx]), 64'(vecs[i].y));
         chk($sformatf("vec%0d_dir", i), 64'(cap_dir[idx]), 64'(vecs[i].dir));
         chk($sformatf("vec%0d_wv", i), 64'(cap_wv[idx]), 64'(vecs[i].wv));
      end

      // Stall three cycles at beat 5, then abort with reset at beat 12
      ready = 1'b1;
      start_frame();
      repeat (5) @(negedge clk);
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_addr", i), 64'(addr), 64'(pack3(5, 13, 21)));
         chk($sformatf("stall%0d_x", i), 64'(x_out), 64'd5);
         chk($sformatf("stall%0d_valid", i), 64'(valid), 64'd1);
      end
      ready = 1'b1;
      @(negedge clk);
      chk("post_stall_addr", 64'(addr), 64'(pack3(6, 14, 22)));
      repeat (6) @(negedge clk);
      chk("beat12_x", 64'(x_out), 64'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", 64'(valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(frame_done), 64'd0);
      chk("abort_addr", 64'(addr), 64'd0);
      chk("abort_xyd", 64'({x_out, y_out, dir_out, win_valid}), 64'd0);
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (frame_done || valid) bad = 1'b1;
      end
      chk("abort_stays_idle", 64'(bad), 64'd0);
      start_frame();
      chk("restart_addr", 64'(addr), 64'(pack3(0, 8, 16)));
      chk("restart_x", 64'(x_out), 64'd0);
      run_to_done("t2_done");
      @(negedge clk);

      // start held high: ignored in RUN, re-accepted in the frame_done cycle
      start = 1'b1;
      ready = 1'b1;
      @(negedge clk);
      nb = 0; seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (frame_done) begin
            seen = 1'b1;
            break;
         end
         if (valid) nb++;
         @(negedge clk);
      end
      chk("t3_done_seen", 64'(seen), 64'd1);
      chk("t3_beats", 64'(nb), 64'(BEATS));
      chk("t3_done_valid", 64'(valid), 64'd0);
      @(negedge clk);
      chk("t3_next_valid", 64'(valid), 64'd1);
      chk("t3_next_addr", 64'(addr), 64'(pack3(0, 8, 16)));
      chk("t3_next_y", 64'(y_out), 64'd0);
      start = 1'b0;
      run_to_done("t3_done2");
      @(negedge clk);

`ifdef RAM_BASE_EN
      set_base(16'h0100);
      start_frame();
      chk("base_addr", 64'(addr), 64'(pack3(16'h100, 16'h108, 16'h110)));
      do_reset();
      set_base(16'hFFF8);
      start_frame();
      chk("base_wrap_lane0", 64'(addr[0 +: AW]), 64'hFFF8);
      chk("base_wrap_lane1", 64'(addr[AW +: AW]), 64'h0000);
      do_reset();
`endif

      // Random ready against the reference beat list
      for (int f = 0; f < 6; f++) begin
         set_base(AW'($urandom));
         fill_model();
         ready = 1'b0;
         repeat ($urandom_range(3, 0)) @(negedge clk);
         start_frame();
         for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            b = exp_q[0];
            chk("rnd_valid", 64'(valid), 64'd1);
            chk("rnd_busy", 64'(busy), 64'd1);
            chk("rnd_done", 64'(frame_done), 64'd0);
            chk("rnd_addr", 64'(addr), 64'(b.addr));
            chk("rnd_x", 64'(x_out), 64'(b.col));
            chk("rnd_y", 64'(y_out), 64'(b.y));
            chk("rnd_dir", 64'(dir_out), 64'(b.dir));
            chk("rnd_wv", 64'(win_valid), 64'(b.wv));
            ready = ($urandom_range(9, 0) < 7);
            if (ready) void'(exp_q.pop_front());
            @(negedge clk);
         end
         chk("rnd_all_beats", 64'(exp_q.size()), 64'd0);
         chk("rnd_end_done", 64'(frame_done), 64'd1);
         chk("rnd_end_valid", 64'(valid), 64'd0);
         chk("rnd_end_busy", 64'(busy), 64'd0);
         @(negedge clk);
         chk("rnd_end_pulse", 64'(frame_done), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
